mux8_rr_arbiter: RTL and testbench

//  - Round-robin arbiter sharing one 8:1 single-bit data mux among 8 requesters.
//  - Registers a one-hot grant plus a binary select; the select drives the mux S[2:0].
//  - A grant is held while its requester keeps req high. After MAX_HOLD cycles it is

---
 rtl/mux8_arb_pkg.sv | 20 ++
 rtl/rr_pick8.sv | 35 +++
 rtl/mux8_rr_arbiter.sv | 111 +++++++++++
 tb/tb_mux8_rr_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux8_arb_pkg.sv
// Shared constants, state type and helpers for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } state_e;

    function automatic logic [N-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set bit of (req & ~mask) searching from ptr upward,
// wrapping mod 8.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N-1:0]     mask,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [N-1:0]     eff;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [SEL_W-1:0] off;

    assign eff = req & ~mask;
    // Rotating the doubled vector right by ptr puts bit ptr at position 0.
    assign dbl = {eff, eff} >> ptr;
    assign rot = dbl[N-1:0];

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign found = |rot;
    assign idx   = off + ptr;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for a shared 8:1 mux: registered one-hot grant, binary select and a
// saturating hold counter with MAX_HOLD preemption unless lock is held.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             lock,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] sel,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SEL_W-1:0] sel_next;
    logic [SEL_W-1:0] pick_ptr;
    logic [N-1:0]     pick_mask;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             release_own;
    logic             preempt;

    assign sel_next = sel_q + 1'b1;

    // While granted, the search starts just past the holder and skips it.
    assign pick_ptr  = (state_q == GRANT) ? sel_next : ptr_q;
    assign pick_mask = (state_q == GRANT) ? onehot8(sel_q) : '0;

    assign release_own = !req[sel_q];
    assign preempt     = (cnt_q >= HoldLast) && !lock && ((req & ~gnt_q) != '0);

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = onehot8(pick_idx);
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_own || preempt) begin
                    ptr_d = sel_next;
                    cnt_d = '0;
                    if (pick_found) begin
                        gnt_d = onehot8(pick_idx);
                        sel_d = pick_idx;
                    end else begin
                        // sel keeps the last owner so the mux select stays quiet
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (cnt_q != HoldLast) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt       = gnt_q;
        gnt_valid = |gnt_q;
        sel       = sel_q;
        hold_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed vectors with literal expectations plus an
// integer-level round-robin model compared on every falling edge.
module tb_mux8_rr_arbiter;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       lock;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] sel;
    logic [4:0] hold_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    mux8_rr_arbiter #(
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .sel       (sel),
        .hold_cnt  (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: owner index (-1 = none), priority pointer, cycles held, last select.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_sel   = 0;
    int m_win;
    bit m_others;

    function automatic int pick(input logic [7:0] r, input int p, input int excl);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (p + k) % 8;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
            m_sel   = 0;
        end else if (m_owner < 0) begin
            m_win = pick(req, m_ptr, -1);
            if (m_win >= 0) begin
                m_owner = m_win;
                m_sel   = m_win;
                m_cnt   = 0;
            end
        end else begin
            m_others = 1'b0;
            for (int k = 0; k < 8; k++) if (k != m_owner && req[k]) m_others = 1'b1;
            if (!req[m_owner] || (m_cnt >= MAX_HOLD - 1 && !lock && m_others)) begin
                m_ptr = (m_owner + 1) % 8;
                m_win = pick(req, m_ptr, m_owner);
                m_owner = m_win;
                m_cnt   = 0;
                if (m_win >= 0) m_sel = m_win;
            end else if (m_cnt < MAX_HOLD - 1) begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("model gnt", gnt, (m_owner < 0) ? 32'h0 : (32'h1 << m_owner));
            chk("model gnt_valid", gnt_valid, (m_owner >= 0) ? 32'h1 : 32'h0);
            chk("model sel", sel, m_sel);
            if (m_owner >= 0) chk("model hold_cnt", hold_cnt, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] r;
        logic       l;
        int         cyc;
    } vec_t;

    vec_t vecs[7] = '{
        '{8'hFF, 1'b0, 40},
        '{8'hA5, 1'b0, 40},
        '{8'h5A, 1'b1, 25},
        '{8'h01, 1'b0, 10},
        '{8'h81, 1'b0, 40},
        '{8'h00, 1'b0, 5},
        '{8'h3C, 1'b0, 70}
    };

    initial begin
        reset = 1'b1;
        req   = 8'h00;
        lock  = 1'b0;
        repeat (2) tick();
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Idle after reset
        repeat (5) begin
            tick();
            chk("idle gnt", gnt, 8'h00);
            chk("idle gnt_valid", gnt_valid, 1'b0);
            chk("idle sel", sel, 3'd0);
        end

        // Two requesters, release handoff and pointer wrap
        req = 8'h81;
        tick();
        chk("first gnt", gnt, 8'h01);
        chk("first sel", sel, 3'd0);
        req = 8'h80;
        tick();
        chk("handoff gnt", gnt, 8'h80);
        chk("handoff sel", sel, 3'd7);
        req = 8'h00;
        tick();
        chk("drain gnt_valid", gnt_valid, 1'b0);
        chk("drain sel kept", sel, 3'd7);
        req = 8'h03;
        tick();
        chk("ptr wrap gnt", gnt, 8'h01);
        req = 8'h00;
        repeat (2) tick();

        // Preemption after MAX_HOLD cycles, ptr now 1
        req = 8'h06;
        for (int i = 0; i < MAX_HOLD; i++) begin
            tick();
            chk("hold02 gnt", gnt, 8'h02);
        end
        chk("hold02 cnt sat", hold_cnt, 5'd15);
        tick();
        chk("preempt gnt", gnt, 8'h04);
        chk("preempt sel", sel, 3'd2);
        for (int i = 1; i < MAX_HOLD; i++) begin
            tick();
            chk("hold04 gnt", gnt, 8'h04);
        end
        tick();
        chk("back gnt", gnt, 8'h02);
        req = 8'h00;
        repeat (2) tick();

        // Lock holds the grant indefinitely
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lock  = 1'b1;
        req   = 8'h06;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("lock gnt", gnt, 8'h02);
            chk("lock hold_cnt", hold_cnt, (i < 15) ? i : 15);
        end
        lock = 1'b0;
        tick();
        chk("unlock preempt gnt", gnt, 8'h04);
        req = 8'h00;
        repeat (2) tick();

        // Release with simultaneous new request: no bubble
        req = 8'h08;
        tick();
        chk("owner3 gnt", gnt, 8'h08);
        req = 8'h10;
        tick();
        chk("swap gnt", gnt, 8'h10);
        chk("swap gnt_valid", gnt_valid, 1'b1);
        req = 8'h00;
        repeat (2) tick();

        // Asynchronous reset mid-grant
        req = 8'h20;
        tick();
        chk("pre-reset gnt", gnt, 8'h20);
        tick();
        reset = 1'b1;
        #1;
        chk("async rst gnt", gnt, 8'h00);
        chk("async rst gnt_valid", gnt_valid, 1'b0);
        chk("async rst sel", sel, 3'd0);
        chk("async rst hold_cnt", hold_cnt, 5'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post-reset gnt", gnt, 8'h20);
        chk("post-reset sel", sel, 3'd5);
        req = 8'h00;
        repeat (2) tick();

        // Pattern table and a deterministic per-cycle sweep, checked by the model
        foreach (vecs[v]) begin
            req  = vecs[v].r;
            lock = vecs[v].l;
            repeat (vecs[v].cyc) tick();
        end
        lock = 1'b0;
        for (int i = 0; i < 120; i++) begin
            req  = 8'((i * 37) ^ (i >> 1));
            lock = (i % 29) > 20;
            tick();
        end
        req  = 8'h00;
        lock = 1'b0;
        repeat (3) tick();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
